// File: rtl/eff_tremolo_lfo.sv
// -----------------------------------------------------------------------------
// eff_tremolo_lfo
//   Tremolo effect. A signed audio stream is amplitude-modulated by an internal
//   LFO. The LFO phase advances once per accepted sample (vld_i & en), so the
//   modulation rate is tied to the sample rate rather than to clk. The fixed
//   3-stage pipeline has the same latency in bypass and in effect mode.
//
// Ports
//   clk       system clock
//   rst       asynchronous reset, active-high
//   en        1 = tremolo applied, 0 = bit-exact bypass (LFO phase held)
//   rate      phase increment per accepted sample (unsigned)
//   depth     modulation depth, 0 = none, 2^L-1 = full
//   shape     00 triangle, 01 square, 10 saw-down, 11 triangle
//   lfo_sync  clears the LFO phase (retrigger), wins over the increment
//   data_i    input sample, signed
//   vld_i     data_i valid this cycle
//   data_o    output sample, signed; holds its last value while vld_o = 0
//   vld_o     data_o valid, vld_i delayed by exactly 3 clocks
//   lfo_o     registered LFO value w (LED/debug)
// -----------------------------------------------------------------------------
module eff_tremolo_lfo #(
  parameter int DATA_WIDTH  = 8,
  parameter int LFO_WIDTH   = 8,
  parameter int PHASE_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [PHASE_WIDTH-1:0]        rate,
  input  logic [LFO_WIDTH-1:0]          depth,
  input  logic [1:0]                    shape,
  input  logic                          lfo_sync,
  input  logic signed [DATA_WIDTH-1:0]  data_i,
  input  logic                          vld_i,
  output logic signed [DATA_WIDTH-1:0]  data_o,
  output logic                          vld_o,
  output logic [LFO_WIDTH-1:0]          lfo_o
);

  localparam int PROD_W = DATA_WIDTH + LFO_WIDTH + 1;
  localparam logic [LFO_WIDTH:0] UNITY_GAIN = {1'b1, {LFO_WIDTH{1'b0}}};

  // g = en ? 2^L - ((depth * (2^L-1-w)) >> L) : 2^L
  // The full 2L-bit product is kept so the shift floors the exact value.
  function automatic logic [LFO_WIDTH:0] calc_gain(
    input logic                 en_a,
    input logic [LFO_WIDTH-1:0] depth_a,
    input logic [LFO_WIDTH-1:0] w_a
  );
    logic [2*LFO_WIDTH-1:0] prod;
    logic [LFO_WIDTH-1:0]   inv_w;
    inv_w = ~w_a;
    prod  = {{LFO_WIDTH{1'b0}}, depth_a} * {{LFO_WIDTH{1'b0}}, inv_w};
    if (en_a)
      return UNITY_GAIN - (LFO_WIDTH+1)'(prod >> LFO_WIDTH);
    else
      return UNITY_GAIN;
  endfunction

  // Signed sample times unsigned gain. Operands are extended by hand so the
  // multiply is done at full width; |p| <= 2^(DATA_WIDTH-1) * 2^L fits PROD_W.
  function automatic logic signed [PROD_W-1:0] mul_gain(
    input logic signed [DATA_WIDTH-1:0] d_a,
    input logic [LFO_WIDTH:0]           g_a
  );
    logic signed [PROD_W:0] de;
    logic signed [PROD_W:0] ge;
    de = {{(PROD_W+1-DATA_WIDTH){d_a[DATA_WIDTH-1]}}, d_a};
    ge = {{(PROD_W-LFO_WIDTH){1'b0}}, g_a};
    return PROD_W'(de * ge);
  endfunction

  // Arithmetic shift = floor rounding. g <= 2^L so the result always fits.
  function automatic logic signed [DATA_WIDTH-1:0] scale_floor(
    input logic signed [PROD_W-1:0] p_a
  );
    return DATA_WIDTH'(p_a >>> LFO_WIDTH);
  endfunction

  logic [PHASE_WIDTH-1:0]        phase_q, phase_d;
  logic [LFO_WIDTH:0]            t;
  logic [LFO_WIDTH-1:0]          w;
  logic [LFO_WIDTH-1:0]          lfo_q;
  logic [LFO_WIDTH:0]            gain_d;

  logic signed [DATA_WIDTH-1:0]  data_p1_q;
  logic [LFO_WIDTH:0]            gain_p1_q;
  logic                          vld_p1_q;
  logic signed [PROD_W-1:0]      prod_p2_q;
  logic                          vld_p2_q;
  logic signed [DATA_WIDTH-1:0]  data_p3_q;
  logic                          vld_p3_q;

  always_comb begin
    phase_d = phase_q;
    if (lfo_sync)
      phase_d = '0;
    else if (vld_i && en)
      phase_d = phase_q + rate;
  end

  // LFO value from the pre-increment phase.
  assign t = phase_q[PHASE_WIDTH-1 -: LFO_WIDTH+1];

  always_comb begin
    w = t[LFO_WIDTH-1:0];
    case (shape)
      2'b01:   w = t[LFO_WIDTH] ? '0 : '1;
      2'b10:   w = ~t[LFO_WIDTH-1:0];
      default: w = t[LFO_WIDTH] ? ~t[LFO_WIDTH-1:0] : t[LFO_WIDTH-1:0];
    endcase
  end

  assign gain_d = calc_gain(en, depth, w);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q   <= '0;
      lfo_q     <= '0;
      data_p1_q <= '0;
      gain_p1_q <= '0;
      vld_p1_q  <= 1'b0;
      prod_p2_q <= '0;
      vld_p2_q  <= 1'b0;
      data_p3_q <= '0;
      vld_p3_q  <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      lfo_q     <= w;
      // stage 1: capture sample, gain and valid together
      data_p1_q <= data_i;
      gain_p1_q <= gain_d;
      vld_p1_q  <= vld_i;
      // stage 2: multiply
      prod_p2_q <= mul_gain(data_p1_q, gain_p1_q);
      vld_p2_q  <= vld_p1_q;
      // stage 3: scale back, update output only for valid samples
      if (vld_p2_q)
        data_p3_q <= scale_floor(prod_p2_q);
      vld_p3_q  <= vld_p2_q;
    end
  end

  assign data_o = data_p3_q;
  assign vld_o  = vld_p3_q;
  assign lfo_o  = lfo_q;

endmodule

// File: tb/tb_eff_tremolo_lfo.sv
module tb_eff_tremolo_lfo;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic [15:0]       rate;
  logic [7:0]        depth;
  logic [1:0]        shape;
  logic              lfo_sync;
  logic signed [7:0] data_i;
  logic              vld_i;
  logic signed [7:0] data_o;
  logic              vld_o;
  logic [7:0]        lfo_o;

  int n_total = 0;
  int n_pass  = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  eff_tremolo_lfo #(.DATA_WIDTH(8), .LFO_WIDTH(8), .PHASE_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .en(en), .rate(rate), .depth(depth), .shape(shape),
    .lfo_sync(lfo_sync), .data_i(data_i), .vld_i(vld_i),
    .data_o(data_o), .vld_o(vld_o), .lfo_o(lfo_o)
  );

  typedef struct {
    logic        en;
    logic [7:0]  depth;
    logic [1:0]  shape;
    int          din;
    int          dexp;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // One clock of streaming: check any output first, then drive the next input.
  task automatic step(input logic v, input int d, input int e);
    int x;
    @(negedge clk);
    if (vld_o) begin
      if (exp_q.size() == 0) chk("unexpected_vld_o", 1, 0);
      else begin
        x = exp_q.pop_front();
        chk("stream_data", int'(data_o), x);
      end
    end
    vld_i  = v;
    data_i = 8'(d);
    if (v) exp_q.push_back(e);
  endtask

  task automatic drain();
    repeat (5) step(1'b0, 0, 0);
    chk("stream_drained", exp_q.size(), 0);
  endtask

  task automatic sync_phase();
    lfo_sync = 1'b1;
    step(1'b0, 0, 0);
    lfo_sync = 1'b0;
  endtask

  // Single isolated sample; measures latency and checks the result.
  task automatic send_one(input int d, input int e, input string name);
    int lat;
    @(negedge clk);
    vld_i  = 1'b1;
    data_i = 8'(d);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      vld_i = 1'b0;
    end while (!vld_o && lat < 8);
    chk({name, "_latency"}, lat, 3);
    chk({name, "_data"}, int'(data_o), e);
  endtask

  initial begin
    // en, depth, shape, data, expected  (phase cleared to 0, rate 0)
    vecs[0]  = '{1'b0, 8'd255, 2'b00, -100, -100};
    vecs[1]  = '{1'b1, 8'd0,   2'b00,  127,  127};
    vecs[2]  = '{1'b1, 8'd0,   2'b01, -128, -128};
    vecs[3]  = '{1'b1, 8'd0,   2'b10,   -1,   -1};
    vecs[4]  = '{1'b1, 8'd255, 2'b00,  100,    0};
    vecs[5]  = '{1'b1, 8'd255, 2'b00, -100,   -1};
    vecs[6]  = '{1'b1, 8'd255, 2'b11,  127,    0};
    vecs[7]  = '{1'b1, 8'd128, 2'b00,  100,   50};
    vecs[8]  = '{1'b1, 8'd128, 2'b00, -100,  -51};
    vecs[9]  = '{1'b1, 8'd255, 2'b01,   77,   77};
    vecs[10] = '{1'b1, 8'd255, 2'b10,  -50,  -50};
    vecs[11] = '{1'b1, 8'd64,  2'b00,  127,   95};
    vecs[12] = '{1'b1, 8'd64,  2'b00, -128,  -97};

    rst = 1'b1; en = 1'b0; rate = '0; depth = '0; shape = 2'b00;
    lfo_sync = 1'b0; data_i = '0; vld_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_vld_o", int'(vld_o), 0);
    chk("reset_data_o", int'(data_o), 0);
    rst = 1'b0;

    // Async reset mid-stream
    en = 1'b0; data_i = 8'sd50; vld_i = 1'b1;
    repeat (5) @(negedge clk);
    chk("pre_reset_vld_o", int'(vld_o), 1);
    chk("pre_reset_data_o", int'(data_o), 50);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_vld_o", int'(vld_o), 0);
    chk("async_reset_data_o", int'(data_o), 0);
    chk("async_reset_lfo_o", int'(lfo_o), 0);
    @(negedge clk);
    rst = 1'b0; vld_i = 1'b0;
    send_one(-7, -7, "post_reset");

    // Table-driven vectors
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      en = vecs[i].en; depth = vecs[i].depth; shape = vecs[i].shape;
      rate = '0; lfo_sync = 1'b1;
      @(negedge clk);
      lfo_sync = 1'b0;
      send_one(vecs[i].din, vecs[i].dexp, $sformatf("vec%0d", i));
    end

    // Bypass holds phase: move to w=64, then 1000 bypassed samples
    en = 1'b1; shape = 2'b00; depth = 8'd0; rate = 16'd256;
    sync_phase();
    for (int i = 0; i < 32; i++) step(1'b1, i, i);
    drain();
    chk("lfo_w64", int'(lfo_o), 64);
    en = 1'b0; depth = 8'd255;
    for (int i = 0; i < 1000; i++) step(1'b1, -100, -100);
    drain();
    chk("bypass_phase_held", int'(lfo_o), 64);

    // Square wave, full depth
    en = 1'b1; shape = 2'b01; depth = 8'd255; rate = 16'd256;
    sync_phase();
    for (int i = 0; i < 256; i++) begin
      if (i < 128) step(1'b1, 100, 100);
      else if (i % 2 == 1) step(1'b1, -100, -1);
      else step(1'b1, 100, 0);
    end
    drain();

    // Triangle period with gaps
    shape = 2'b00; depth = 8'd0; rate = 16'd256;
    sync_phase();
    for (int i = 0; i < 64; i++) step(1'b1, i, i);
    repeat (2) step(1'b0, 0, 0);
    chk("tri_64", int'(lfo_o), 128);
    for (int i = 0; i < 64; i++) begin
      step(1'b1, -i, -i);
      if (i % 3 == 0) step(1'b0, 0, 0);
    end
    repeat (2) step(1'b0, 0, 0);
    chk("tri_128_gapped", int'(lfo_o), 255);
    for (int i = 0; i < 128; i++) begin
      step(1'b1, 3, 3);
      if (i % 5 == 0) repeat (2) step(1'b0, 0, 0);
    end
    repeat (2) step(1'b0, 0, 0);
    chk("tri_period_256", int'(lfo_o), 0);
    drain();

    // lfo_sync coincident with a valid sample
    sync_phase();
    for (int i = 0; i < 40; i++) step(1'b1, 1, 1);
    repeat (2) step(1'b0, 0, 0);
    chk("pre_sync_lfo", int'(lfo_o), 80);
    step(1'b1, 9, 9);
    lfo_sync = 1'b1;
    step(1'b0, 0, 0);
    lfo_sync = 1'b0;
    step(1'b0, 0, 0);
    chk("sync_restart_w0", int'(lfo_o), 0);
    step(1'b1, 5, 5);
    repeat (2) step(1'b0, 0, 0);
    chk("sync_next_w2", int'(lfo_o), 2);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
